// File: rtl/sync_counter_n.sv
// sync_counter_n: '163-style mod-MODULUS counter, cascadable via rco; SYNC_COUNTER_UPDOWN_EN adds down-count
module sync_counter_n #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load_b,
  input  logic             ep,
  input  logic             et,
  input  logic             up,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             rco
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_up_nxt;
  logic [WIDTH-1:0] w_step;
  logic             w_tc;
  // compare before incrementing so out-of-range loads wrap and nothing overflows WIDTH
  assign w_up_nxt = (r_q >= MAX) ? '0 : r_q + WIDTH'(1);
`ifdef SYNC_COUNTER_UPDOWN_EN
  logic [WIDTH-1:0] w_dn_nxt;
  assign w_dn_nxt = (r_q == '0 || r_q > MAX) ? MAX : r_q - WIDTH'(1);
  assign w_step   = up ? w_up_nxt : w_dn_nxt;
  assign w_tc     = up ? (r_q == MAX) : (r_q == '0);
`else
  logic w_unused;
  assign w_unused = up;
  assign w_step   = w_up_nxt;
  assign w_tc     = (r_q == MAX);
`endif
  always_ff @(posedge clk) begin
    if (clear) r_q <= '0;
    else if (!load_b) r_q <= d;
    else if (ep && et) r_q <= w_step;
  end
  assign q   = r_q;
  assign rco = et & w_tc;
endmodule

// File: tb/tb_sync_counter_n.sv
// tb_sync_counter_n: directed checks of a mod-10 counter and a two-stage mod-100 cascade
module tb_sync_counter_n;
  logic       clk = 1'b0;
  logic       clear = 1'b1, load_b = 1'b1, ep = 1'b0, et = 1'b0, up = 1'b1;
  logic [3:0] d = 4'd0;
  logic [3:0] q;
  logic       rco;
  logic       cclr = 1'b1, cep = 1'b0;
  logic [3:0] q0, q1;
  logic       rco0, rco1;
  int         n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  sync_counter_n #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .clear(clear), .load_b(load_b), .ep(ep), .et(et), .up(up),
    .d(d), .q(q), .rco(rco));
  sync_counter_n #(.WIDTH(4), .MODULUS(10)) c0 (
    .clk(clk), .clear(cclr), .load_b(1'b1), .ep(cep), .et(1'b1), .up(1'b1),
    .d(4'd0), .q(q0), .rco(rco0));
  sync_counter_n #(.WIDTH(4), .MODULUS(10)) c1 (
    .clk(clk), .clear(cclr), .load_b(1'b1), .ep(cep), .et(rco0), .up(1'b1),
    .d(4'd0), .q(q1), .rco(rco1));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    step();
    chk("reset_q", q, 0);
    chk("reset_rco_et0", rco, 0);
    et = 1'b1;
    #1 chk("reset_rco_et1", rco, 0);
    clear = 1'b0; ep = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("count_q", q, (i + 1) % 10);
      chk("count_rco", rco, ((i + 1) % 10) == 9);
    end
    load_b = 1'b0; d = 4'd13;
    step();
    chk("load_oor_q", q, 13);
    chk("load_oor_rco", rco, 0);
    load_b = 1'b1;
    step();
    chk("oor_wrap", q, 0);
    clear = 1'b1; load_b = 1'b0; d = 4'd5;
    step();
    chk("clear_over_load", q, 0);
    clear = 1'b0; d = 4'd9; ep = 1'b0;
    step();
    chk("load9", q, 9);
    chk("load9_rco", rco, 1);
    load_b = 1'b1; ep = 1'b1; et = 1'b0;
    #1 chk("et0_rco", rco, 0);
    step();
    chk("et0_hold", q, 9);
    et = 1'b1;
    #1 chk("et1_rco", rco, 1);
    step();
    chk("et1_wrap", q, 0);
    load_b = 1'b0; d = 4'd9;
    step();
    load_b = 1'b1; ep = 1'b0;
    step();
    chk("ep0_hold", q, 9);
    chk("ep0_rco", rco, 1);
    ep = 1'b1; load_b = 1'b0; d = 4'd3;
    step();
    chk("load_over_count", q, 3);
    load_b = 1'b1; clear = 1'b1;
    step();
    chk("mid_clear", q, 0);
    clear = 1'b0;
    step();
    chk("resume", q, 1);
`ifdef SYNC_COUNTER_UPDOWN_EN
    clear = 1'b1;
    step();
    clear = 1'b0; up = 1'b0;
    #1 chk("dn_rco_at0", rco, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("dn_q", q, 9 - i);
      chk("dn_rco", rco, 0);
    end
    load_b = 1'b0; d = 4'd12;
    step();
    chk("dn_load12", q, 12);
    load_b = 1'b1;
    step();
    chk("dn_oor", q, 9);
    up = 1'b1;
    #1 chk("dir_flip_rco", rco, 1);
    step();
    chk("dir_flip_q", q, 0);
`else
    clear = 1'b1;
    step();
    clear = 1'b0; up = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("up_ignored", q, i + 1);
    end
`endif
    step();
    chk("casc_reset", {q1, q0}, 8'h00);
    cclr = 1'b0; cep = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      chk("casc_q", {q1, q0}, {4'((i + 1) % 100 / 10), 4'((i + 1) % 10)});
      chk("casc_rco", rco1, ((i + 1) % 100) == 99);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
